// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two sources share one register-file write port (fixed priority + starvation guard).
// Optional macro WB_BYPASS_EN adds combinational write-through forwarding for two read ports.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              write_ena,
    output logic [ADDR_W-1:0] regw_addr,
    output logic [DATA_W-1:0] write_data
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [DATA_W-1:0] rf_rd1_data,
    input  logic [ADDR_W-1:0] rf_rd2_addr,
    input  logic [DATA_W-1:0] rf_rd2_data,
    output logic [DATA_W-1:0] fwd_rd1_data,
    output logic [DATA_W-1:0] fwd_rd2_data
`endif
);

    localparam int unsigned       CNT_W = 4;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic              grant0;
    logic              grant1;
    logic              starve_hit;

    logic [CNT_W-1:0]  starve_cnt_d, starve_cnt_q;
    logic              write_ena_d,  write_ena_q;
    logic [ADDR_W-1:0] regw_addr_d,  regw_addr_q;
    logic [DATA_W-1:0] write_data_d, write_data_q;

    assign starve_hit = (starve_cnt_q == LIMIT);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !flush) begin
            if (starve_hit && req1_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Counts consecutive cycles in which req1 waited and lost; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (rst || flush || grant1 || !req1_valid) begin
            starve_cnt_d = '0;
        end else if (!starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // x0 grants are consumed but never raise write_ena; address/data hold when nothing is written.
    always_comb begin
        write_ena_d  = 1'b0;
        regw_addr_d  = regw_addr_q;
        write_data_d = write_data_q;
        if (grant0 && (req0_addr != '0)) begin
            write_ena_d  = 1'b1;
            regw_addr_d  = req0_addr;
            write_data_d = req0_data;
        end else if (grant1 && (req1_addr != '0)) begin
            write_ena_d  = 1'b1;
            regw_addr_d  = req1_addr;
            write_data_d = req1_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            write_ena_q  <= 1'b0;
            regw_addr_q  <= '0;
            write_data_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            write_ena_q  <= write_ena_d;
            regw_addr_q  <= regw_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_ena  = write_ena_q;
    assign regw_addr  = regw_addr_q;
    assign write_data = write_data_q;

`ifdef WB_BYPASS_EN
    // Covers the cycle a write is presented but not yet committed by the register file.
    always_comb begin
        fwd_rd1_data = rf_rd1_data;
        fwd_rd2_data = rf_rd2_data;
        if (write_ena_q && (regw_addr_q == rf_rd1_addr) && (rf_rd1_addr != '0)) begin
            fwd_rd1_data = write_data_q;
        end
        if (write_ena_q && (regw_addr_q == rf_rd2_addr) && (rf_rd2_addr != '0)) begin
            fwd_rd2_data = write_data_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_LIMIT=4); WB_BYPASS_EN adds forwarding checks.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        write_ena;
    logic [4:0]  regw_addr;
    logic [31:0] write_data;
`ifdef WB_BYPASS_EN
    logic [4:0]  rf_rd1_addr;
    logic [31:0] rf_rd1_data;
    logic [4:0]  rf_rd2_addr;
    logic [31:0] rf_rd2_data;
    logic [31:0] fwd_rd1_data;
    logic [31:0] fwd_rd2_data;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .write_ena  (write_ena),
        .regw_addr  (regw_addr),
        .write_data (write_data)
`ifdef WB_BYPASS_EN
        ,
        .rf_rd1_addr  (rf_rd1_addr),
        .rf_rd1_data  (rf_rd1_data),
        .rf_rd2_addr  (rf_rd2_addr),
        .rf_rd2_data  (rf_rd2_data),
        .fwd_rd1_data (fwd_rd1_data),
        .fwd_rd2_data (fwd_rd2_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        req0_data  = 32'h9999_9999;
        req1_valid = 1'b1;
        req1_addr  = 5'd10;
        req1_data  = 32'hAAAA_AAAA;
`ifdef WB_BYPASS_EN
        rf_rd1_addr = '0;
        rf_rd1_data = '0;
        rf_rd2_addr = '0;
        rf_rd2_data = '0;
`endif

        // Reset held 3 cycles with both sources valid.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_ready0", 32'(req0_ready), 32'd0);
            check("rst_ready1", 32'(req1_ready), 32'd0);
            tick();
        end
        check("rst_write_ena",  32'(write_ena),  32'd0);
        check("rst_regw_addr",  32'(regw_addr),  32'd0);
        check("rst_write_data", write_data,      32'd0);
        check("rst_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);

        // Single source: req0 writes x5.
        rst        = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEAD_BEEF;
        #1;
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("single_write_ena",  32'(write_ena), 32'd1);
        check("single_regw_addr",  32'(regw_addr), 32'd5);
        check("single_write_data", write_data,     32'hDEAD_BEEF);
        tick();
        check("idle_write_ena",  32'(write_ena), 32'd0);
        check("idle_regw_hold",  32'(regw_addr), 32'd5);
        check("idle_data_hold",  write_data,     32'hDEAD_BEEF);

        // Contention: req0 wins 4, req1 wins 1, repeating.
        req0_valid = 1'b1;
        req0_addr  = 5'd1;
        req0_data  = 32'h1111_0001;
        req1_valid = 1'b1;
        req1_addr  = 5'd2;
        req1_data  = 32'h2222_0002;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("cont_starve_cnt", 32'(dut.starve_cnt_q), 32'(i % 5));
            check("cont_ready0", 32'(req0_ready), (i % 5 == 4) ? 32'd0 : 32'd1);
            check("cont_ready1", 32'(req1_ready), (i % 5 == 4) ? 32'd1 : 32'd0);
            tick();
            check("cont_write_ena", 32'(write_ena), 32'd1);
            check("cont_regw_addr", 32'(regw_addr), (i % 5 == 4) ? 32'd2 : 32'd1);
            check("cont_write_data", write_data,
                  (i % 5 == 4) ? 32'h2222_0002 : 32'h1111_0001);
        end
        check("cont_starve_wrap", 32'(dut.starve_cnt_q), 32'd0);

        // x0 write from req1 is consumed without a register-file write.
        req0_valid = 1'b0;
        req1_addr  = 5'd0;
        req1_data  = 32'h0000_1234;
        #1;
        check("x0_ready1", 32'(req1_ready), 32'd1);
        tick();
        check("x0_write_ena", 32'(write_ena), 32'd0);

        // Flush: a presented write still completes, no grants, starve count cleared.
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'h0000_0033;
        req1_valid = 1'b1;
        req1_addr  = 5'd4;
        req1_data  = 32'h0000_0044;
        #1;
        check("pre_flush_ready0", 32'(req0_ready), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check("flush_ready0", 32'(req0_ready), 32'd0);
        check("flush_ready1", 32'(req1_ready), 32'd0);
        check("flush_inflight_ena",  32'(write_ena), 32'd1);
        check("flush_inflight_addr", 32'(regw_addr), 32'd3);
        check("flush_starve_before", 32'(dut.starve_cnt_q), 32'd1);
        tick();
        flush = 1'b0;
        check("flush_write_ena",  32'(write_ena), 32'd0);
        check("flush_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);
        #1;
        check("post_flush_ready0", 32'(req0_ready), 32'd1);

        // Reset rising mid-transfer voids the grant.
        rst       = 1'b1;
        req0_addr = 5'd6;
        req0_data = 32'h0000_0066;
        #1;
        check("rst_mid_ready0", 32'(req0_ready), 32'd0);
        tick();
        check("rst_mid_write_ena", 32'(write_ena), 32'd0);
        check("rst_mid_regw_addr", 32'(regw_addr), 32'd0);
        rst        = 1'b0;
        req1_valid = 1'b0;

`ifdef WB_BYPASS_EN
        // Forwarding of a presented write to x7.
        req0_addr = 5'd7;
        req0_data = 32'hA5A5_A5A5;
        #1;
        tick();
        req0_valid  = 1'b0;
        rf_rd1_addr = 5'd7;
        rf_rd1_data = 32'h0000_0011;
        rf_rd2_addr = 5'd0;
        rf_rd2_data = 32'h0000_0022;
        #1;
        check("fwd_rd1_hit",  fwd_rd1_data, 32'hA5A5_A5A5);
        check("fwd_rd2_x0",   fwd_rd2_data, 32'h0000_0022);
        rf_rd1_addr = 5'd8;
        #1;
        check("fwd_rd1_miss", fwd_rd1_data, 32'h0000_0011);
        tick();
        rf_rd1_addr = 5'd7;
        #1;
        check("fwd_rd1_idle", fwd_rd1_data, 32'h0000_0011);
`else
        req0_valid = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
